// File: rtl/memory_stage.sv
// OTTER pipeline memory stage: sized loads/stores over a req/ack bus with wait-state stall and timeout abort.
// Optional alignment checking is enabled by defining MEM_MISALIGN_CHECK_EN.
module memory_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALUResultM,
    output logic [31:0] ALUResultM2,
    output logic        StallM,
    output logic        DmemReq,
    output logic        DmemWe,
    output logic [31:0] DmemAddr,
    output logic [31:0] DmemWData,
    output logic [3:0]  DmemBe,
    input  logic        DmemAck,
    input  logic [31:0] DmemRData,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic        BusErrW,
    output logic        MisalignW
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    state_t      state_q;
    logic [7:0]  wcnt_q;
    logic        regWrite_q;
    logic [1:0]  resultSrc_q;
    logic [4:0]  rd_q;
    logic [31:0] aluResult_q;
    logic [31:0] readData_q;
    logic [31:0] pcPlus4_q;
    logic        busErr_q;
    logic        misalign_q;

    logic [1:0]  off;
    logic        isLoad;
    logic        isAccess;
    logic        misalign;
    logic        issue;
    logic        atLimit;
    logic        abort;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] readData_d;

    assign off      = ALUResultM[1:0];
    assign isLoad   = (ResultSrcM == 2'b01);
    assign isAccess = MemWriteM | isLoad;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = isAccess &&
                      (((Funct3M[1:0] == 2'b01) && off[0]) ||
                       (Funct3M[1] && (off != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign issue   = isAccess & ~misalign;
    assign atLimit = (wcnt_q == MaxWait);
    assign abort   = (state_q == ST_WAIT) & ~DmemAck & atLimit;

    // Request and stall are gated by reset so an in-flight access is dropped the instant reset asserts.
    assign DmemReq = RESET_N & (((state_q == ST_IDLE) & issue) | (state_q == ST_WAIT));
    assign StallM  = RESET_N & ~DmemAck &
                     (((state_q == ST_IDLE) & issue) | ((state_q == ST_WAIT) & ~atLimit));

    assign ALUResultM2 = ALUResultM;
    assign DmemAddr    = {ALUResultM[31:2], 2'b00};
    assign DmemWe      = MemWriteM;

    always_comb begin
        DmemBe    = 4'b1111;
        DmemWData = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                DmemWData = {4{WriteDataM[7:0]}};
                if (MemWriteM) DmemBe = 4'b0001 << off;
            end
            2'b01: begin
                DmemWData = {2{WriteDataM[15:0]}};
                if (MemWriteM) DmemBe = 4'b0011 << {off[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (off)
            2'b00:   byteSel = DmemRData[7:0];
            2'b01:   byteSel = DmemRData[15:8];
            2'b10:   byteSel = DmemRData[23:16];
            default: byteSel = DmemRData[31:24];
        endcase
        halfSel = off[1] ? DmemRData[31:16] : DmemRData[15:0];
        case (Funct3M)
            3'b000:  readData_d = {{24{byteSel[7]}}, byteSel};
            3'b100:  readData_d = {24'd0, byteSel};
            3'b001:  readData_d = {{16{halfSel[15]}}, halfSel};
            3'b101:  readData_d = {16'd0, halfSel};
            default: readData_d = DmemRData;
        endcase
        if (!isLoad) readData_d = 32'd0;
    end

    // Wait-state FSM and MEM/WB register; stall cycles push a bubble, abort and misalign push a marked dead entry.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 8'd0;
            regWrite_q  <= 1'b0;
            resultSrc_q <= 2'b00;
            rd_q        <= 5'd0;
            aluResult_q <= 32'd0;
            readData_q  <= 32'd0;
            pcPlus4_q   <= 32'd0;
            busErr_q    <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue && !DmemAck) begin
                        state_q <= ST_WAIT;
                        wcnt_q  <= 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (DmemAck || atLimit) begin
                        state_q <= ST_IDLE;
                        wcnt_q  <= 8'd0;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (StallM) begin
                regWrite_q <= 1'b0;
                busErr_q   <= 1'b0;
                misalign_q <= 1'b0;
            end else begin
                resultSrc_q <= ResultSrcM;
                rd_q        <= RdM;
                aluResult_q <= ALUResultM;
                pcPlus4_q   <= PCPlus4M;
                if (abort || misalign) begin
                    regWrite_q <= 1'b0;
                    readData_q <= 32'd0;
                end else begin
                    regWrite_q <= RegWriteM;
                    readData_q <= readData_d;
                end
                busErr_q   <= abort;
                misalign_q <= misalign;
            end
        end
    end

    assign RegWriteW  = regWrite_q;
    assign ResultSrcW = resultSrc_q;
    assign RdW        = rd_q;
    assign ALUResultW = aluResult_q;
    assign ReadDataW  = readData_q;
    assign PCPlus4W   = pcPlus4_q;
    assign BusErrW    = busErr_q;
    assign MisalignW  = misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: table of zero-wait accesses plus wait-state, timeout and reset sequences.
// Honours MEM_MISALIGN_CHECK_EN for the misaligned-word vector.
module tb_memory_stage;

    logic        CLK;
    logic        RESET_N;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M, WriteDataM, ALUResultM;
    logic [31:0] ALUResultM2;
    logic        StallM, DmemReq, DmemWe;
    logic [31:0] DmemAddr, DmemWData;
    logic [3:0]  DmemBe;
    logic        DmemAck;
    logic [31:0] DmemRData;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic        BusErrW, MisalignW;

    int checks = 0;
    int errors = 0;

    memory_stage #(.MAX_WAIT(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .RdM(RdM), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALUResultM(ALUResultM), .ALUResultM2(ALUResultM2), .StallM(StallM),
        .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr), .DmemWData(DmemWData),
        .DmemBe(DmemBe), .DmemAck(DmemAck), .DmemRData(DmemRData),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .BusErrW(BusErrW), .MisalignW(MisalignW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        memW;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic        regW;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic        eReq;
        logic [3:0]  eBe;
        logic [31:0] eWData;
        logic        eRegW;
        logic [31:0] eRead;
        logic        eMis;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic memW, input logic [1:0] rs, input logic [2:0] f3,
                                 input logic regW, input logic [4:0] rd, input logic [31:0] alu,
                                 input logic [31:0] wd, input logic [31:0] pc4);
        MemWriteM  = memW;
        ResultSrcM = rs;
        Funct3M    = f3;
        RegWriteM  = regW;
        RdM        = rd;
        ALUResultM = alu;
        WriteDataM = wd;
        PCPlus4M   = pc4;
    endtask

    initial begin
        int stalls;

        // Zero-wait accesses (ack in the same cycle) and a non-access pass-through.
        vecs[0]  = '{1'b1, 2'b00, 3'b010, 1'b0, 5'd1, 32'h100, 32'h11223344, 32'h0,        32'h104,
                     1'b1, 4'b1111, 32'h11223344, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 2'b00, 3'b001, 1'b0, 5'd2, 32'h302, 32'h1234ABCD, 32'h0,        32'h108,
                     1'b1, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 3'b000, 1'b0, 5'd3, 32'h101, 32'hFFFFFF5A, 32'h0,        32'h10C,
                     1'b1, 4'b0010, 32'h5A5A5A5A, 1'b0, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 2'b00, 3'b000, 1'b0, 5'd4, 32'h103, 32'h000000C3, 32'h0,        32'h110,
                     1'b1, 4'b1000, 32'hC3C3C3C3, 1'b0, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 2'b01, 3'b101, 1'b1, 5'd5, 32'h302, 32'h0,        32'hBEEF0000, 32'h114,
                     1'b1, 4'b1111, 32'h0, 1'b1, 32'h0000BEEF, 1'b0};
        vecs[5]  = '{1'b0, 2'b01, 3'b001, 1'b1, 5'd6, 32'h300, 32'h0,        32'h12348001, 32'h118,
                     1'b1, 4'b1111, 32'h0, 1'b1, 32'hFFFF8001, 1'b0};
        vecs[6]  = '{1'b0, 2'b01, 3'b100, 1'b1, 5'd7, 32'h201, 32'h0,        32'h11229344, 32'h11C,
                     1'b1, 4'b1111, 32'h0, 1'b1, 32'h00000093, 1'b0};
        vecs[7]  = '{1'b0, 2'b01, 3'b000, 1'b1, 5'd8, 32'h202, 32'h0,        32'h11229344, 32'h120,
                     1'b1, 4'b1111, 32'h0, 1'b1, 32'h00000022, 1'b0};
        vecs[8]  = '{1'b0, 2'b01, 3'b010, 1'b1, 5'd9, 32'h404, 32'h0,        32'hCAFEF00D, 32'h124,
                     1'b1, 4'b1111, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b0, 2'b00, 3'b010, 1'b1, 5'd10, 32'hDEADBEEF, 32'h0,  32'h55555555, 32'h128,
                     1'b0, 4'b1111, 32'h0, 1'b1, 32'h0, 1'b0};
`ifdef MEM_MISALIGN_CHECK_EN
        vecs[10] = '{1'b0, 2'b01, 3'b010, 1'b1, 5'd11, 32'h401, 32'h0,       32'h600DF00D, 32'h12C,
                     1'b0, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b1};
`else
        vecs[10] = '{1'b0, 2'b01, 3'b010, 1'b1, 5'd11, 32'h401, 32'h0,       32'h600DF00D, 32'h12C,
                     1'b1, 4'b1111, 32'h0, 1'b1, 32'h600DF00D, 1'b0};
`endif

        RESET_N   = 1'b0;
        DmemAck   = 1'b0;
        DmemRData = 32'h0;
        applyStimulus(1'b0, 2'b00, 3'b000, 1'b1, 5'd31, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);

        #12;
        checkOutput("rst RegWriteW",  RegWriteW,  32'd0);
        checkOutput("rst ALUResultW", ALUResultW, 32'd0);
        checkOutput("rst RdW",        RdW,        32'd0);
        checkOutput("rst PCPlus4W",   PCPlus4W,   32'd0);
        checkOutput("rst BusErrW",    BusErrW,    32'd0);
        checkOutput("rst MisalignW",  MisalignW,  32'd0);
        checkOutput("rst DmemReq",    DmemReq,    32'd0);
        RESET_N = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].memW, vecs[i].rs, vecs[i].f3, vecs[i].regW, vecs[i].rd,
                          vecs[i].alu, vecs[i].wd, vecs[i].pc4);
            DmemAck   = 1'b1;
            DmemRData = vecs[i].rdata;
            #3;
            checkOutput($sformatf("v%0d DmemReq", i),     DmemReq,     vecs[i].eReq);
            checkOutput($sformatf("v%0d StallM", i),      StallM,      32'd0);
            checkOutput($sformatf("v%0d DmemWe", i),      DmemWe,      vecs[i].memW);
            checkOutput($sformatf("v%0d DmemBe", i),      DmemBe,      vecs[i].eBe);
            checkOutput($sformatf("v%0d DmemWData", i),   DmemWData,   vecs[i].eWData);
            checkOutput($sformatf("v%0d DmemAddr", i),    DmemAddr,    vecs[i].alu & 32'hFFFFFFFC);
            checkOutput($sformatf("v%0d ALUResultM2", i), ALUResultM2, vecs[i].alu);
            @(posedge CLK); #1;
            checkOutput($sformatf("v%0d RegWriteW", i),  RegWriteW,  vecs[i].eRegW);
            checkOutput($sformatf("v%0d ReadDataW", i),  ReadDataW,  vecs[i].eRead);
            checkOutput($sformatf("v%0d MisalignW", i),  MisalignW,  vecs[i].eMis);
            checkOutput($sformatf("v%0d BusErrW", i),    BusErrW,    32'd0);
            checkOutput($sformatf("v%0d RdW", i),        RdW,        vecs[i].rd);
            checkOutput($sformatf("v%0d ResultSrcW", i), ResultSrcW, vecs[i].rs);
            checkOutput($sformatf("v%0d ALUResultW", i), ALUResultW, vecs[i].alu);
            checkOutput($sformatf("v%0d PCPlus4W", i),   PCPlus4W,   vecs[i].pc4);
        end

        // lb at 0x203 with two wait states: bubbles while stalled, then sign-extended byte 3.
        applyStimulus(1'b0, 2'b01, 3'b000, 1'b1, 5'd12, 32'h203, 32'h0, 32'h208);
        stalls = 0;
        for (int c = 0; c < 10; c++) begin
            DmemAck   = (c == 2);
            DmemRData = (c == 2) ? 32'h80FF0000 : 32'h0;
            #3;
            if (!StallM) break;
            stalls++;
            checkOutput("lb DmemReq", DmemReq, 32'd1);
            @(posedge CLK); #1;
            checkOutput("lb bubble RegWriteW", RegWriteW, 32'd0);
        end
        checkOutput("lb stall cycles", stalls, 32'd2);
        @(posedge CLK); #1;
        checkOutput("lb RegWriteW", RegWriteW, 32'd1);
        checkOutput("lb ReadDataW", ReadDataW, 32'hFFFFFF80);
        checkOutput("lb RdW",       RdW,       32'd12);

        // lw that never gets an ack: aborts after MAX_WAIT stall cycles.
        applyStimulus(1'b0, 2'b01, 3'b010, 1'b1, 5'd13, 32'h500, 32'h0, 32'h504);
        DmemAck   = 1'b0;
        DmemRData = 32'hFFFFFFFF;
        stalls = 0;
        for (int c = 0; c < 20; c++) begin
            #3;
            if (!StallM) break;
            stalls++;
            @(posedge CLK); #1;
        end
        checkOutput("to stall cycles", stalls, 32'd4);
        checkOutput("to abort DmemReq", DmemReq, 32'd1);
        @(posedge CLK); #1;
        checkOutput("to BusErrW",    BusErrW,    32'd1);
        checkOutput("to RegWriteW",  RegWriteW,  32'd0);
        checkOutput("to ReadDataW",  ReadDataW,  32'd0);
        checkOutput("to ALUResultW", ALUResultW, 32'h500);
        applyStimulus(1'b0, 2'b00, 3'b000, 1'b1, 5'd3, 32'h12345678, 32'h0, 32'h99);
        #3;
        checkOutput("to next DmemReq", DmemReq, 32'd0);
        checkOutput("to next StallM",  StallM,  32'd0);
        @(posedge CLK); #1;
        checkOutput("to next BusErrW",   BusErrW,   32'd0);
        checkOutput("to next RegWriteW", RegWriteW, 32'd1);

        // Reset while waiting: bus request and stall drop at once, W clears, late ack is ignored.
        applyStimulus(1'b0, 2'b01, 3'b010, 1'b1, 5'd14, 32'h600, 32'h0, 32'h604);
        DmemAck = 1'b0;
        #3;
        checkOutput("rw first StallM", StallM, 32'd1);
        @(posedge CLK); #1;
        #2;
        checkOutput("rw wait StallM",  StallM,  32'd1);
        checkOutput("rw wait DmemReq", DmemReq, 32'd1);
        RESET_N = 1'b0;
        #1;
        checkOutput("rw DmemReq",    DmemReq,    32'd0);
        checkOutput("rw StallM",     StallM,     32'd0);
        checkOutput("rw RegWriteW",  RegWriteW,  32'd0);
        checkOutput("rw ALUResultW", ALUResultW, 32'd0);
        checkOutput("rw RdW",        RdW,        32'd0);
        checkOutput("rw PCPlus4W",   PCPlus4W,   32'd0);
        applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        DmemAck   = 1'b1;
        DmemRData = 32'hFFFFFFFF;
        #2;
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        checkOutput("rw late RegWriteW", RegWriteW, 32'd0);
        checkOutput("rw late ReadDataW", ReadDataW, 32'd0);
        checkOutput("rw late BusErrW",   BusErrW,   32'd0);
        DmemAck = 1'b0;
        #3;
        checkOutput("rw idle DmemReq", DmemReq, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the OTTER pipeline. It sits directly downstream of the execute stage and consumes that stage's M-side pipeline register outputs. It performs byte, halfword and word loads and stores over a req/ack data-memory bus, stalling the pipeline on wait states and aborting on timeout. It drives the MEM/WB pipeline register into writeback and returns the forwarding value to the execute stage.

## Interface
- `MAX_WAIT`, default 15: number of wait cycles allowed for `DmemAck` before the access is aborted. Legal range is 1-255.
- `CLK` in 1: single clock. All state updates on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `RegWriteM`, `MemWriteM` in 1: control signals from the execute stage.
- `ResultSrcM` in 2: result select. `2'b01` marks a load.
- `Funct3M` in 3: access size and sign. `000`=b, `001`=h, `010`=w, `100`=bu, `101`=hu.
- `RdM` in 5; `PCPlus4M`, `WriteDataM`, `ALUResultM` in 32 each.
- `ALUResultM2` out 32: forwarding value to the execute stage. It is `ALUResultM`, combinational.
- `StallM` out 1: to the hazard unit. Freezes fetch, decode and execute, including the execute M register.
- `DmemReq`, `DmemWe` out 1; `DmemAddr` out 32; `DmemWData` out 32; `DmemBe` out 4.
- `DmemAck` in 1; `DmemRData` in 32.
- `RegWriteW` out 1; `ResultSrcW` out 2; `RdW` out 5.
- `ALUResultW`, `ReadDataW`, `PCPlus4W` out 32 each.
- `BusErrW`, `MisalignW` out 1.

## Operation
- An access is any cycle where `MemWriteM` is 1 or `ResultSrcM` is `2'b01`. Call the address offset `off = ALUResultM[1:0]`.
- Bus signals (combinational):
  - `DmemAddr` = `{ALUResultM[31:2],2'b00}`.
  - `DmemWe` = `MemWriteM`.
  - Store byte enables: sb gives `4'b0001<<off`; sh gives `4'b0011<<{off[1],1'b0}`; sw gives `4'b1111`.
  - Store data: sb replicates the byte into all 4 lanes; sh replicates the halfword into both halves; sw passes the word through.
  - For loads, `DmemBe` is `4'b1111`.
- Load extraction from `DmemRData`:
  - b/bu take the byte lane `off`, sign- or zero-extended.
  - h/hu take the halfword lane `off[1]`, sign- or zero-extended.
  - w passes the word through.
- FSM states: IDLE and WAIT. A wait counter `wcnt` is 8 bits.
  - In IDLE with an access, `DmemReq` is 1. If `DmemAck` is 1 the same cycle, the access completes and the state stays IDLE. Otherwise the state moves to WAIT, `wcnt` is set to 1, and `StallM` is 1.
  - In WAIT, `DmemReq` and `StallM` stay 1. On `DmemAck`, the access completes and the state returns to IDLE. Otherwise `wcnt` increments.
  - When `wcnt` equals `MAX_WAIT` without ack, the access aborts and the state returns to IDLE.
  - Non-access instructions pass through in IDLE with `DmemReq` at 0.
- MEM/WB register:
  - On completion or pass-through, it captures all M fields, and `ReadDataW` takes the extracted load data.
  - On every stall cycle it loads a bubble: `RegWriteW`=0, with other fields don't-care but held.
  - On abort it captures the M fields but forces `RegWriteW`=0, `ReadDataW`=0 and `BusErrW`=1. `DmemReq` drops the cycle after the abort edge.
- `BusErrW` and `MisalignW` are 1 only for the single writeback entry they mark.
- The execute stage holds its M outputs stable while `StallM` is 1.

## Timing
- Reset (async, `RESET_N`=0) forces:
  - state IDLE and `wcnt`=0;
  - `RegWriteW`, `BusErrW`, `MisalignW`=0;
  - `ResultSrcW`, `RdW`, `ALUResultW`, `ReadDataW`, `PCPlus4W`=0.
- `DmemReq` and `StallM` go to 0 immediately on reset, because they are gated by state and reset. An outstanding bus transaction is abandoned, and a late `DmemAck` in IDLE with no access is ignored.
- Latency:
  - non-access or zero-wait access: M to W in 1 cycle;
  - N wait states (N < `MAX_WAIT`): `StallM` is high for N cycles, and W is valid N+1 cycles after the instruction enters M;
  - timeout: `StallM` is high for `MAX_WAIT` cycles.
- If `DmemAck` arrives in the same cycle that `wcnt` reaches `MAX_WAIT`, the ack wins and the access completes normally.
- `StallM` is combinational from state and inputs. It is never high in IDLE except on the first cycle of an access that lacks an ack.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined: the stage checks alignment before issuing a request.
  - lh/lhu/sh with `off[0]`=1, and lw/sw with `off`≠0, are misaligned.
  - A misaligned access issues no `DmemReq` and completes in IDLE in 1 cycle.
  - W gets `MisalignW`=1, `RegWriteW`=0 and `ReadDataW`=0.
- `MEM_MISALIGN_CHECK_EN` undefined: `MisalignW` is tied to 0.
  - Words ignore `off`; halfwords use `off[1]` only.
  - All accesses go to the bus.

## Test plan
- **sw zero-wait:** sw `0x11223344` to `0x100` with ack in the same cycle → `DmemBe`=`1111`, `DmemWData`=`0x11223344`, `StallM` never 1, W entry next cycle with `RegWriteW`=0.
- **lb sign-extended:** lb at `0x203` with `DmemRData`=`0x80FF0000`, 2 wait states → `StallM` high 2 cycles, `ReadDataW`=`0xFFFFFF80`, bubbles (`RegWriteW`=0) on the 2 stall cycles.
- **sh / lhu lane select:** sh `0xABCD` at `0x302` gives `DmemBe`=`1100` and `DmemWData`=`0xABCDABCD`. lhu at `0x302` with `DmemRData`=`0xBEEF0000` gives `ReadDataW`=`0x0000BEEF`.
- **Timeout:** `MAX_WAIT`=4, lw with no ack → `StallM` high 4 cycles, then W has `BusErrW`=1, `RegWriteW`=0, `ReadDataW`=0, and `DmemReq` is low on the next cycle.
- **Reset mid-wait:** drop `RESET_N` during WAIT → `DmemReq` and `StallM` go to 0 immediately, all W outputs are 0, and a late ack after reset produces no W entry.
- **Misaligned lw at `0x401`:** with `MEM_MISALIGN_CHECK_EN` defined → no `DmemReq`, `MisalignW`=1, `RegWriteW`=0. With it undefined → request at `0x400`, normal completion.
